aibnd_dcc_dly_ctrl: RTL
=======================

AIBND_DCC_DLY_CTRL -- requirements
Module: aibnd_dcc_dly_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent DCC delay channels.
REQ-002 SHALL have parameter CODE_W, default 10: delay-code width per channel.
REQ-003 SHALL have parameter SETTLE_CYC, default 8: wait cycles between measure pulse and phase-detector sample, legal range 1..255.
REQ-004 SHALL have parameter LOCK_REV, default 4: direction reversals per channel required for lock, legal range 1..15.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  level-sampled; starts or restarts calibration.
REQ-009 pd_up  input  NUM_CH  per-channel phase-detector result; 1 = increase delay, 0 = decrease.
REQ-010 launch  output  1  one-cycle launch pulse to the delay line.
REQ-011 measure  output  1  one-cycle measure pulse to the delay line.
REQ-012 gray  output  NUM_CH*CODE_W  registered Gray-coded delay code; channel k occupies bits [k*CODE_W +: CODE_W].
REQ-013 dll_lock_reg  output  1  all channels locked.
REQ-014 busy  output  1  FSM not in IDLE or LOCKED.
REQ-015 ch_sat  output  NUM_CH  channel code is at 0 or at 2^CODE_W-1.

Function
REQ-016 SHALL implement an FSM with states IDLE, LAUNCH, MEASURE, SETTLE, SAMPLE and LOCKED.
REQ-017 IDLE -> LAUNCH when start=1; otherwise SHALL remain in IDLE.
REQ-018 LAUNCH SHALL last 1 cycle with launch=1, then go to MEASURE.
REQ-019 MEASURE SHALL last 1 cycle with measure=1, then go to SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles, counted by a down-counter, then go to SAMPLE.
REQ-021 SAMPLE SHALL last 1 cycle and sample pd_up for every channel.
  - pd_up=1 and channel unlocked: code +1, saturating at 2^CODE_W-1.
  - pd_up=0 and channel unlocked: code -1, saturating at 0.
  - Locked channel: code held.
REQ-022 A reversal SHALL be counted when a channel's step direction differs from its previous step direction; the first step after reset or restart SHALL NOT count as a reversal.
REQ-023 A channel SHALL lock when its reversal count reaches LOCK_REV.
REQ-024 A channel pinned at a saturation limit for LOCK_REV consecutive samples SHALL also lock, with ch_sat held at 1.
REQ-025 From SAMPLE, the FSM SHALL go to LOCKED if all channels are locked after the update, else to LAUNCH.
REQ-026 gray SHALL equal bin ^ (bin >> 1) of each channel's binary code, registered, and SHALL update on the cycle after SAMPLE.
REQ-027 dll_lock_reg SHALL be 1 exactly while in LOCKED, or while tracking under REQ-034.
REQ-028 start=1 in any state other than IDLE SHALL restart calibration.
  - Restart clears lock flags and reversal counters.
  - Codes are retained, not re-centred.
  - FSM goes to LAUNCH on the next cycle; dll_lock_reg falls on the same edge.
REQ-029 If start=1 coincides with SAMPLE, the restart SHALL take priority and that cycle's sample SHALL be discarded.
REQ-030 launch and measure SHALL never be asserted in the same cycle.

Reset
REQ-031 On reset=1, the FSM SHALL go to IDLE.
  - Binary codes = 2^(CODE_W-1); gray = Gray of midscale (10'h300 for CODE_W=10).
  - Reversal counters, lock flags and ch_sat = 0.
  - launch, measure, dll_lock_reg, busy = 0.
REQ-032 Reset asserted mid-calibration SHALL abort within the same edge, with no further launch or measure pulse.

Configuration
REQ-033 The macro AIBND_DCC_TRACK_EN SHALL select tracking mode.
REQ-034 With AIBND_DCC_TRACK_EN defined, LOCKED SHALL re-run the LAUNCH..SAMPLE cycle continuously.
  - Codes step ±1 per SAMPLE regardless of per-channel lock.
  - dll_lock_reg stays 1; busy stays 0.
REQ-035 Without AIBND_DCC_TRACK_EN, LOCKED SHALL be terminal until start or reset, with codes frozen and no launch or measure pulses.

Structure
REQ-036 A shared package aibnd_dcc_pkg SHALL hold the FSM state enum typedef, the default parameter constants and a bin2gray function.
REQ-037 A sub-module aibnd_dcc_ch_ctrl SHALL implement one channel (code register, direction bit, reversal counter, saturation logic) and SHALL be instantiated NUM_CH times by generate.

Verification
REQ-038 The bench SHALL cover the following directed scenarios:
  - Reset, then idle 5 cycles -> gray = {10'h300,10'h300}; launch, measure and dll_lock_reg stay 0.
  - start pulse, pd_up alternating 1,0,1,0,1 per sample (NUM_CH=2, defaults) -> lock after the 5th SAMPLE; code ends at 512 or 513; dll_lock_reg rises the cycle after that SAMPLE; each iteration is exactly 11 cycles.
  - pd_up held 1 on ch0 -> ch0 code saturates at 1023, ch_sat[0]=1, ch0 locks after 4 further pinned samples; ch1 converges independently.
  - start asserted during SETTLE -> next cycle is LAUNCH; dll_lock_reg=0; reversal counts cleared; codes retained.
  - reset asserted mid-SETTLE -> next cycle all outputs are at their reset values and no measure pulse occurs.
  - With AIBND_DCC_TRACK_EN defined, after lock, pd_up=1 for 3 samples -> code +3 and dll_lock_reg stays 1; without the macro -> code unchanged and no launch pulses.

Source files
------------

// File: rtl/aibnd_dcc_pkg.sv
// Shared types, default parameters and Gray helper for the DCC delay controller.
package aibnd_dcc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StMeasure,
    StSettle,
    StSample,
    StLocked
  } dcc_state_e;

  localparam int unsigned NumChDefault     = 2;
  localparam int unsigned CodeWDefault     = 10;
  localparam int unsigned SettleCycDefault = 8;
  localparam int unsigned LockRevDefault   = 4;
  localparam int unsigned MaxCodeW         = 32;

  function automatic logic [MaxCodeW-1:0] bin2gray(input logic [MaxCodeW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/aibnd_dcc_ch_ctrl.sv
// One DCC delay channel: binary code, last step direction, reversal and
// saturation-pin counters, lock flag and registered Gray output.
module aibnd_dcc_ch_ctrl
  import aibnd_dcc_pkg::*;
#(
  parameter int unsigned CODE_W   = CodeWDefault,
  parameter int unsigned LOCK_REV = LockRevDefault
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              sample_i,
  input  logic              track_i,
  input  logic              pd_up_i,
  output logic [CODE_W-1:0] gray_o,
  output logic              sat_o,
  output logic              lock_next_o
);

  localparam logic [CODE_W-1:0] CodeMax    = '1;
  localparam logic [CODE_W-1:0] CodeMid    = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] CodeOne    = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [CODE_W-1:0] GrayMid    = CODE_W'(bin2gray(MaxCodeW'(CodeMid)));
  localparam logic [3:0]        LockRevCnt = 4'(LOCK_REV);

  logic [CODE_W-1:0] code_q, code_d, gray_q;
  logic              dir_q, dir_d, dir_vld_q, dir_vld_d, lock_q, lock_d;
  logic [3:0]        rev_q, rev_d, pin_q, pin_d;
  logic              pinned;

  always_comb begin
    code_d    = code_q;
    dir_d     = dir_q;
    dir_vld_d = dir_vld_q;
    rev_d     = rev_q;
    pin_d     = pin_q;
    lock_d    = lock_q;
    // A step that would push past a limit leaves the code where it is.
    pinned    = pd_up_i ? (code_q == CodeMax) : (code_q == '0);
    if (clear_i) begin
      dir_vld_d = 1'b0;
      rev_d     = '0;
      pin_d     = '0;
      lock_d    = 1'b0;
    end else if (sample_i && (!lock_q || track_i)) begin
      if (!pinned) code_d = pd_up_i ? code_q + CodeOne : code_q - CodeOne;
      dir_d     = pd_up_i;
      dir_vld_d = 1'b1;
      if (!lock_q) begin
        if (dir_vld_q && (pd_up_i != dir_q) && (rev_q != LockRevCnt)) rev_d = rev_q + 4'd1;
        if (!pinned)                    pin_d = '0;
        else if (pin_q != LockRevCnt)   pin_d = pin_q + 4'd1;
        lock_d = (rev_d == LockRevCnt) || (pin_d == LockRevCnt);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      code_q    <= CodeMid;
      gray_q    <= GrayMid;
      dir_q     <= 1'b0;
      dir_vld_q <= 1'b0;
      rev_q     <= '0;
      pin_q     <= '0;
      lock_q    <= 1'b0;
    end else begin
      code_q    <= code_d;
      gray_q    <= CODE_W'(bin2gray(MaxCodeW'(code_d)));
      dir_q     <= dir_d;
      dir_vld_q <= dir_vld_d;
      rev_q     <= rev_d;
      pin_q     <= pin_d;
      lock_q    <= lock_d;
    end
  end

  assign gray_o      = gray_q;
  assign sat_o       = (code_q == '0) || (code_q == CodeMax);
  assign lock_next_o = lock_d;

endmodule

// File: rtl/aibnd_dcc_dly_ctrl.sv
// DCC delay-line calibration controller: launch/measure/settle/sample loop per channel.
// Define AIBND_DCC_TRACK_EN to keep stepping the codes continuously after lock.
module aibnd_dcc_dly_ctrl
  import aibnd_dcc_pkg::*;
#(
  parameter int unsigned NUM_CH     = NumChDefault,
  parameter int unsigned CODE_W     = CodeWDefault,
  parameter int unsigned SETTLE_CYC = SettleCycDefault,
  parameter int unsigned LOCK_REV   = LockRevDefault
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        pd_up,
  output logic                     launch,
  output logic                     measure,
  output logic [NUM_CH*CODE_W-1:0] gray,
  output logic                     dll_lock_reg,
  output logic                     busy,
  output logic [NUM_CH-1:0]        ch_sat
);

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);

  dcc_state_e        state_q;
  logic [7:0]        settle_q;
  logic              track_q;
  logic              sample_en;
  logic [NUM_CH-1:0] lock_next;

  // A coinciding restart discards the sample.
  assign sample_en = (state_q == StSample) && !start;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    aibnd_dcc_ch_ctrl #(
      .CODE_W  (CODE_W),
      .LOCK_REV(LOCK_REV)
    ) u_ch (
      .clk_i      (clk),
      .reset_i    (reset),
      .clear_i    (start),
      .sample_i   (sample_en),
      .track_i    (track_q),
      .pd_up_i    (pd_up[k]),
      .gray_o     (gray[k*CODE_W +: CODE_W]),
      .sat_o      (ch_sat[k]),
      .lock_next_o(lock_next[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      settle_q     <= '0;
      track_q      <= 1'b0;
      launch       <= 1'b0;
      measure      <= 1'b0;
      dll_lock_reg <= 1'b0;
      busy         <= 1'b0;
    end else if (start) begin
      state_q      <= StLaunch;
      track_q      <= 1'b0;
      launch       <= 1'b1;
      measure      <= 1'b0;
      dll_lock_reg <= 1'b0;
      busy         <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLaunch: begin
          state_q <= StMeasure;
          launch  <= 1'b0;
          measure <= 1'b1;
        end
        StMeasure: begin
          state_q  <= StSettle;
          measure  <= 1'b0;
          settle_q <= SettleLoad;
        end
        StSettle: begin
          if (settle_q == '0) state_q <= StSample;
          else                settle_q <= settle_q - 8'd1;
        end
        StSample: begin
          if (track_q) begin
            state_q <= StLaunch;
            launch  <= 1'b1;
          end else if (&lock_next) begin
            state_q      <= StLocked;
            dll_lock_reg <= 1'b1;
            busy         <= 1'b0;
          end else begin
            state_q <= StLaunch;
            launch  <= 1'b1;
          end
        end
        StLocked: begin
`ifdef AIBND_DCC_TRACK_EN
          state_q <= StLaunch;
          launch  <= 1'b1;
          track_q <= 1'b1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
